// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: MEM-stage request/response bundle between the core and the data-memory stage.
// The err signal exists only when MEM_STAGE_ERR_EN is defined.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
`ifdef MEM_STAGE_ERR_EN
    logic              err;
`endif

    modport master (
`ifdef MEM_STAGE_ERR_EN
        input  err,
`endif
        output mem_r_en, mem_w_en, address, wdata,
        input  rdata, ready, busy
    );

    modport slave (
`ifdef MEM_STAGE_ERR_EN
        output err,
`endif
        input  mem_r_en, mem_w_en, address, wdata,
        output rdata, ready, busy
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: multi-cycle word-addressed data memory that stalls the pipeline via ready.
// Optional MEM_STAGE_ERR_EN adds a registered err flag for out-of-range or misaligned accesses.
module mem_stage_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    mem_stage_ctrl_if.slave  bus
);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int CNT_W  = $clog2(WAIT_CYCLES) + 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] index;
    logic              req, in_range, last, fire;

    assign req      = bus.mem_r_en | bus.mem_w_en;
    // addresses below BASE_ADDR wrap to huge indices and fall out of range
    assign index    = (bus.address - ADDR_W'(BASE_ADDR)) >> BYTE_W;
    assign in_range = index < ADDR_W'(DEPTH);
    assign last     = cnt_q == CNT_W'(WAIT_CYCLES - 1);
    assign fire     = (state_q == WAIT) && req && last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (!req) state_d = IDLE;
                  else if (last) state_d = DONE;
                  else cnt_d = cnt_q + 1'b1;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // a simultaneous read and write is a write, leaving rdata untouched
    assign rdata_d = (fire && bus.mem_r_en && !bus.mem_w_en) ? (in_range ? mem_q[index[IDX_W-1:0]] : '0) : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            busy_q  <= state_d != IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fire && bus.mem_w_en && in_range) mem_q[index[IDX_W-1:0]] <= bus.wdata;
    end

`ifdef MEM_STAGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else err_q <= fire && (!in_range || (bus.address[BYTE_W-1:0] != '0));
    end

    assign bus.err = err_q;
`endif

    assign bus.ready = ~req | (state_q == DONE);
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;
endmodule
